// File: rtl/alu_mul_seq.sv
// alu_mul_seq -- sequential unsigned 16x16->32 multiplier that borrows the
// shared execute-stage ALU. Shift-and-add: each multiplier bit costs one SLL
// cycle (partial = a << idx) and one ADD cycle (acc += b[idx] ? partial : 0).
// The execute stage muxes the alu_* drive outputs onto the ALU while busy.
//
// Build option: define MUL_SEQ_SKIP_ZERO_EN to visit only the set bits of
// op_b (latency 2*popcount(op_b)+1). Default: all 16 bits, latency 33.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   request a multiply (accepted only in IDLE)
//   abort     in   cancel an in-flight multiply
//   op_a      in   16-bit multiplicand, sampled on accepted start
//   op_b      in   16-bit multiplier, sampled on accepted start
//   busy      out  high in SHIFT, ADD and DONE
//   done      out  one-cycle pulse in DONE
//   product   out  32-bit result, held until the next completion
//   alu_in0   out  ALU operand 0
//   alu_in1   out  ALU operand 1
//   alu_shamt out  ALU shift amount
//   alu_ctrl  out  ALU opcode (ADD=4'h0, SLL=4'h5)
//   alu_out   in   ALU result, combinational in the same cycle
module alu_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic [31:0] alu_in0,
  output logic [31:0] alu_in1,
  output logic [4:0]  alu_shamt,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ADD   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SLL = 4'h5;

  state_t      state, state_nx;
  logic [15:0] a_q, b_q;
  logic [3:0]  idx;
  logic [31:0] partial, acc;

  logic [3:0]  first_idx;
  logic [3:0]  next_idx;
  logic        last_idx;
  logic        accept;

  assign accept = start & ~abort;

`ifdef MUL_SEQ_SKIP_ZERO_EN
  // First index: lowest set bit of op_b. Next index: lowest set bit of b_q
  // strictly above idx; none left means the current ADD is the last one.
  always_comb begin
    logic found;
    first_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (op_b[i] && !found) begin
        first_idx = 4'(i);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    next_idx = idx;
    last_idx = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin
      if (b_q[i] && (i > 32'(idx)) && last_idx) begin
        next_idx = 4'(i);
        last_idx = 1'b0;
      end
    end
  end
`else
  assign first_idx = '0;
  assign next_idx  = idx + 4'd1;
  assign last_idx  = (idx == 4'hF);
`endif

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
`ifdef MUL_SEQ_SKIP_ZERO_EN
          state_nx = (op_b == '0) ? S_DONE : S_SHIFT;
`else
          state_nx = S_SHIFT;
`endif
        end
      end
      S_SHIFT: state_nx = abort ? S_IDLE : S_ADD;
      S_ADD: begin
        if (abort)         state_nx = S_IDLE;
        else if (last_idx) state_nx = S_DONE;
        else               state_nx = S_SHIFT;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Moore outputs and ALU drive
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    alu_ctrl  = ALU_ADD;
    alu_in0   = '0;
    alu_in1   = '0;
    alu_shamt = '0;
    case (state)
      S_SHIFT: begin
        busy      = 1'b1;
        alu_ctrl  = ALU_SLL;
        alu_in0   = {16'h0, a_q};
        alu_shamt = {1'b0, idx};
      end
      S_ADD: begin
        busy     = 1'b1;
        alu_ctrl = ALU_ADD;
        alu_in0  = acc;
        alu_in1  = b_q[idx] ? partial : '0;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      partial <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q <= op_a;
            b_q <= op_b;
            acc <= '0;
            idx <= first_idx;
`ifdef MUL_SEQ_SKIP_ZERO_EN
            if (op_b == '0) product <= '0;
`endif
          end
        end
        S_SHIFT: begin
          if (!abort) partial <= alu_out;
        end
        S_ADD: begin
          // Aborted operations must leave product untouched.
          if (!abort) begin
            acc <= alu_out;
            if (last_idx) product <= alu_out;
            else          idx     <= next_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
